// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that issues one requester's operation to a shared combinational ALU and holds the result until it is accepted.
module alu_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  input  logic [N_REQ*OP_W-1:0]     req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_r,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic                      busy
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, gnt, off;
  logic [IW:0] sum;
  logic [2*N_REQ-1:0] dbl;
  logic any;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [OP_W-1:0] sel_op;
  // Rotating the doubled valid vector puts rr_ptr at bit 0, so the lowest set bit is the winner's offset.
  always_comb begin
    dbl = {req_valid, req_valid} >> rr_ptr;
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) off = dbl[k] ? IW'(k) : off;
    sum = {1'b0, rr_ptr} + {1'b0, off};
    gnt = IW'(sum >= (IW+1)'(N_REQ) ? sum - (IW+1)'(N_REQ) : sum);
    any = |req_valid;
    sel_a = '0;
    sel_b = '0;
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a = gnt == IW'(i) ? req_a[i*DATA_W +: DATA_W] : sel_a;
      sel_b = gnt == IW'(i) ? req_b[i*DATA_W +: DATA_W] : sel_b;
      sel_op = gnt == IW'(i) ? req_op[i*OP_W +: OP_W] : sel_op;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (any ? EXEC : IDLE) :
               state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else begin
      if (state == IDLE && any) begin
        alu_a <= sel_a;
        alu_b <= sel_b;
        alu_op <= sel_op;
        rsp_id <= gnt;
      end
      if (state == EXEC) rsp_data <= alu_r;
      if (state == RESP && rsp_ready) rr_ptr <= rsp_id == IW'(N_REQ - 1) ? '0 : rsp_id + 1'b1;
    end
  end
  assign req_ready = (rst_n && state == IDLE && any) ? N_REQ'(1) << gnt : '0;
  assign busy = rst_n && state != IDLE;
  assign rsp_valid = rst_n && state == RESP;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter (3 requesters) against a transaction-level model.
module tb_alu_arbiter;
  localparam int N = 3, DW = 32, OW = 4;
  logic clk = 0, rst_n = 0, rsp_ready = 0;
  logic [N-1:0] vld = '0, drop = '0, req_ready;
  logic [DW-1:0] pa[N], pb[N];
  logic [OW-1:0] po[N];
  logic [N*DW-1:0] req_a, req_b;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0] alu_a, alu_b, alu_r, rsp_data;
  logic [OW-1:0] alu_op;
  logic rsp_valid, busy;
  logic [1:0] rsp_id;
  int tests = 0, fails = 0, ptr = 0, age = -1, exp_id = 0, nobs;
  logic [DW-1:0] exp_data = '0, last_a = '0, last_b = '0;
  logic [OW-1:0] last_op = '0;
  int obs[$];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = pa[i];
      req_b[i*DW +: DW] = pb[i];
      req_op[i*OW +: OW] = po[i];
    end

  function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      default: return ~a;
    endcase
  endfunction

  assign alu_r = alu_f(alu_a, alu_b, alu_op);

  alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock: drive at negedge, compare mid-cycle, then advance the model to the coming edge.
  task automatic tick(input logic [N-1:0] newv, input logic rr, input logic rst, input bit rnd = 1);
    int g;
    @(negedge clk);
    vld &= ~drop;
    drop = '0;
    for (int i = 0; i < N; i++)
      if (newv[i] && !vld[i]) begin
        vld[i] = 1'b1;
        if (rnd) begin
          pa[i] = $urandom;
          pb[i] = $urandom;
          po[i] = OW'($urandom_range(0, 7));
        end
      end
    rsp_ready = rr;
    rst_n = rst;
    #1;
    g = pick(vld, ptr);
    check("req_ready", DW'(req_ready), (rst && age < 0 && g >= 0) ? DW'(1) << g : DW'(0));
    check("busy", DW'(busy), DW'(rst && age >= 0));
    check("rsp_valid", DW'(rsp_valid), DW'(rst && age >= 2));
    if (rst && age >= 2) begin
      check("rsp_data", rsp_data, exp_data);
      check("rsp_id", DW'(rsp_id), DW'(exp_id));
    end
    check("alu_a", alu_a, last_a);
    check("alu_b", alu_b, last_b);
    check("alu_op", DW'(alu_op), DW'(last_op));
    if (rst && rsp_valid && rr) obs.push_back(int'(rsp_id));
    if (!rst) begin
      ptr = 0;
      age = -1;
      last_a = '0;
      last_b = '0;
      last_op = '0;
    end else if (age < 0 && g >= 0) begin
      exp_id = g;
      exp_data = alu_f(pa[g], pb[g], po[g]);
      last_a = pa[g];
      last_b = pb[g];
      last_op = po[g];
      drop[g] = 1'b1;
      age = 1;
    end else if (age == 1) age = 2;
    else if (age >= 2 && rr) begin
      ptr = (exp_id + 1) % N;
      age = -1;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
      po[i] = '0;
    end
    vld = 3'b011;
    repeat (2) @(negedge clk);
    check("rst_req_ready", DW'(req_ready), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_rsp_valid", DW'(rsp_valid), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", DW'(alu_op), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", DW'(rsp_id), 0);
    vld = '0;

    pa[0] = 5;
    pb[0] = 3;
    po[0] = 0;
    tick(3'b001, 1, 1, 0);
    tick(3'b000, 1, 1);
    check("single_alu_a", alu_a, 5);
    check("single_alu_b", alu_b, 3);
    tick(3'b000, 1, 1);
    check("single_valid", DW'(rsp_valid), 1);
    check("single_data", rsp_data, 8);
    check("single_id", DW'(rsp_id), 0);

    tick(3'b010, 0, 1);
    tick(3'b000, 0, 1);
    repeat (5) tick(3'b101, 0, 1);
    check("bp_data_held", rsp_data, exp_data);
    check("bp_id_held", DW'(rsp_id), 1);
    tick(3'b000, 1, 1);
    repeat (12) tick(3'b000, 1, 1);

    tick(3'b010, 1, 1);
    tick(3'b000, 1, 0);
    tick(3'b000, 1, 1);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_rsp_id", DW'(rsp_id), 0);
    check("abort_busy", DW'(busy), 0);
    nobs = obs.size();
    repeat (4) tick(3'b000, 1, 1);
    check("abort_no_rsp", DW'(obs.size()), DW'(nobs));

    obs.delete();
    for (int c = 0; c < 40 && obs.size() < 6; c++) tick(3'b011, 1, 1);
    check("fair_count", DW'(obs.size()), 6);
    for (int k = 0; k < obs.size() && k < 6; k++) check("fair_id", DW'(obs[k]), DW'(k % 2));
    repeat (12) tick(3'b000, 1, 1);

    tick(3'b000, 1, 0);
    obs.delete();
    for (int c = 0; c < 20 && obs.size() < 1; c++) tick(3'b100, 1, 1);
    for (int c = 0; c < 40 && obs.size() < 3; c++) tick(3'b101, 1, 1);
    check("wrap_count", DW'(obs.size()), 3);
    if (obs.size() >= 3) begin
      check("wrap_first", DW'(obs[0]), 2);
      check("wrap_second", DW'(obs[1]), 0);
      check("wrap_third", DW'(obs[2]), 2);
    end
    repeat (12) tick(3'b000, 1, 1);

    for (int c = 0; c < 400; c++)
      tick(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
